// File: rtl/multi_osc_scheduler_pkg.sv
// Shared types and helpers for the multi-oscillator emulation-time scheduler.
package multi_osc_sched_pkg;

  localparam int unsigned DEF_DT_WIDTH   = 32;
  localparam int unsigned DEF_TIME_WIDTH = 64;

  typedef logic [DEF_DT_WIDTH-1:0]   dt_t;
  typedef logic [DEF_TIME_WIDTH-1:0] emu_time_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  // Zero-length phases are clamped to one unit so the scheduler always advances.
  function automatic dt_t eff_dt(input dt_t x);
    return (x == '0) ? dt_t'(1) : x;
  endfunction

endpackage

// File: rtl/multi_osc_scheduler_if.sv
// Control/status bundle between the testbench harness and the scheduler.
interface multi_osc_scheduler_if
  import multi_osc_sched_pkg::*;
#(
  parameter int unsigned NUM_OSC    = 2,
  parameter int unsigned DT_WIDTH   = DEF_DT_WIDTH,
  parameter int unsigned TIME_WIDTH = DEF_TIME_WIDTH
);
  logic                          en;
  logic [NUM_OSC*DT_WIDTH-1:0]   t_lo;
  logic [NUM_OSC*DT_WIDTH-1:0]   t_hi;
  logic [DT_WIDTH-1:0]           dt_max;
  logic [TIME_WIDTH-1:0]         stop_time;
  logic [NUM_OSC-1:0]            clk_val;
  logic [NUM_OSC-1:0]            clk_edge;
  logic [DT_WIDTH-1:0]           emu_dt;
  logic [TIME_WIDTH-1:0]         emu_time;
  logic                          done;
  logic                          time_ovf;

  modport master (
    output en, t_lo, t_hi, dt_max, stop_time,
    input  clk_val, clk_edge, emu_dt, emu_time, done, time_ovf
  );

  modport slave (
    input  en, t_lo, t_hi, dt_max, stop_time,
    output clk_val, clk_edge, emu_dt, emu_time, done, time_ovf
  );
endinterface

// File: rtl/multi_osc_scheduler_slot.sv
// One emulated oscillator: time to its next edge plus its current level.
module osc_slot
  import multi_osc_sched_pkg::*;
#(
  parameter int unsigned DT_WIDTH = DEF_DT_WIDTH
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [DT_WIDTH-1:0] dt,
  input  logic [DT_WIDTH-1:0] t_lo,
  input  logic [DT_WIDTH-1:0] t_hi,
  output logic [DT_WIDTH-1:0] remain,
  output logic                clk_val,
  output logic                clk_edge
);

  logic                hit;
  logic [DT_WIDTH-1:0] lo_eff;
  logic [DT_WIDTH-1:0] hi_eff;

  assign hit    = (remain == dt);
  assign lo_eff = DT_WIDTH'(eff_dt(dt_t'(t_lo)));
  assign hi_eff = DT_WIDTH'(eff_dt(dt_t'(t_hi)));

  // On a hit the new level is ~clk_val, so reload with the phase being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain   <= '0;
      clk_val  <= 1'b0;
      clk_edge <= 1'b0;
    end else if (load) begin
      remain   <= lo_eff;
      clk_edge <= 1'b0;
    end else if (step) begin
      if (hit) begin
        clk_val  <= ~clk_val;
        clk_edge <= 1'b1;
        remain   <= clk_val ? lo_eff : hi_eff;
      end else begin
        remain   <= remain - dt;
        clk_edge <= 1'b0;
      end
    end else begin
      clk_edge <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_osc_scheduler.sv
// Picks the global step as the nearest oscillator edge and advances emulation time.
module multi_osc_scheduler
  import multi_osc_sched_pkg::*;
#(
  parameter int unsigned NUM_OSC    = 2,
  parameter int unsigned DT_WIDTH   = DEF_DT_WIDTH,
  parameter int unsigned TIME_WIDTH = DEF_TIME_WIDTH
)(
  input  logic                  emu_clk,
  input  logic                  emu_rst_n,
  multi_osc_scheduler_if.slave  bus
);

  sched_state_t          state, state_d;
  logic [DT_WIDTH-1:0]   emu_dt, emu_dt_d;
  logic [TIME_WIDTH-1:0] emu_time, emu_time_d;
  logic                  done, done_d;
  logic                  time_ovf, time_ovf_d;
  logic                  load, step;

  logic [DT_WIDTH-1:0]   remain [NUM_OSC];
  logic                  val_a  [NUM_OSC];
  logic                  edge_a [NUM_OSC];

  logic [TIME_WIDTH-1:0] time_left;
  logic [DT_WIDTH-1:0]   stop_cap;
  logic [DT_WIDTH-1:0]   dt_min;
  logic [TIME_WIDTH:0]   sum;

  for (genvar i = 0; i < NUM_OSC; i++) begin : g_slot
    osc_slot #(.DT_WIDTH(DT_WIDTH)) u_slot (
      .clk      (emu_clk),
      .rst_n    (emu_rst_n),
      .load     (load),
      .step     (step),
      .dt       (dt_min),
      .t_lo     (bus.t_lo[i*DT_WIDTH +: DT_WIDTH]),
      .t_hi     (bus.t_hi[i*DT_WIDTH +: DT_WIDTH]),
      .remain   (remain[i]),
      .clk_val  (val_a[i]),
      .clk_edge (edge_a[i])
    );
  end

  always_comb begin
    bus.clk_val  = '0;
    bus.clk_edge = '0;
    for (int i = 0; i < NUM_OSC; i++) begin
      bus.clk_val[i]  = val_a[i];
      bus.clk_edge[i] = edge_a[i];
    end
  end

  // Step = min(all remains, dt ceiling, time left to stop), saturated to DT_WIDTH.
  always_comb begin
    time_left = bus.stop_time - emu_time;
    if (bus.stop_time == '0 || (|time_left[TIME_WIDTH-1:DT_WIDTH]))
      stop_cap = '1;
    else
      stop_cap = time_left[DT_WIDTH-1:0];
    dt_min = (bus.dt_max == '0) ? '1 : bus.dt_max;
    if (stop_cap < dt_min) dt_min = stop_cap;
    for (int i = 0; i < NUM_OSC; i++)
      if (remain[i] < dt_min) dt_min = remain[i];
  end

  always_comb begin
    state_d    = state;
    emu_dt_d   = '0;
    emu_time_d = emu_time;
    done_d     = done;
    time_ovf_d = time_ovf;
    load       = 1'b0;
    step       = 1'b0;
    sum        = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt_min);
    case (state)
      IDLE: begin
        if (bus.en) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.en) begin
          step       = 1'b1;
          emu_dt_d   = dt_min;
          emu_time_d = sum[TIME_WIDTH-1:0];
          if (sum[TIME_WIDTH]) time_ovf_d = 1'b1;
          if (bus.stop_time != '0 && sum[TIME_WIDTH-1:0] == bus.stop_time) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge emu_clk or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      state    <= IDLE;
      emu_dt   <= '0;
      emu_time <= '0;
      done     <= 1'b0;
      time_ovf <= 1'b0;
    end else begin
      state    <= state_d;
      emu_dt   <= emu_dt_d;
      emu_time <= emu_time_d;
      done     <= done_d;
      time_ovf <= time_ovf_d;
    end
  end

  assign bus.emu_dt   = emu_dt;
  assign bus.emu_time = emu_time;
  assign bus.done     = done;
  assign bus.time_ovf = time_ovf;

endmodule

// File: tb/tb_multi_osc_scheduler.sv
// Directed checks of step selection, toggling, pause, stop and reset behaviour.
module tb_multi_osc_scheduler;

  logic emu_clk;
  logic emu_rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  multi_osc_scheduler_if bus ();

  multi_osc_scheduler dut (
    .emu_clk   (emu_clk),
    .emu_rst_n (emu_rst_n),
    .bus       (bus)
  );

  initial begin
    emu_clk = 1'b0;
    forever #5 emu_clk = ~emu_clk;
  end

  // Reset, program the slots, then take the load edge; returns #1 after it.
  task automatic start(input logic [31:0] lo0, input logic [31:0] lo1,
                       input logic [31:0] hi0, input logic [31:0] hi1,
                       input logic [31:0] dmax, input logic [63:0] stop);
    bus.en    = 1'b0;
    emu_rst_n = 1'b0;
    @(negedge emu_clk);
    bus.t_lo      = {lo1, lo0};
    bus.t_hi      = {hi1, hi0};
    bus.dt_max    = dmax;
    bus.stop_time = stop;
    emu_rst_n     = 1'b1;
    bus.en        = 1'b1;
    @(posedge emu_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.t_lo = '0; bus.t_hi = '0; bus.dt_max = '0; bus.stop_time = '0;
    emu_rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.clk_val, bus.clk_edge, bus.emu_dt, bus.emu_time, bus.done, bus.time_ovf} !== '0)
      $display("FAIL reset_outputs: got val=%b edge=%b dt=%0d time=%0d done=%b ovf=%b expected all zero",
               bus.clk_val, bus.clk_edge, bus.emu_dt, bus.emu_time, bus.done, bus.time_ovf);
    else n_pass++;
  endtask

  task automatic test_basic();
    int         exp_dt   [5] = '{3, 1, 2, 2, 2};
    int         exp_time [5] = '{3, 4, 6, 8, 10};
    logic [1:0] exp_edge [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_val  [5] = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b10};
    start(3, 4, 5, 2, 0, 0);
    n_total++;
    if (bus.emu_dt !== '0 || bus.emu_time !== '0)
      $display("FAIL load_latency: got dt=%0d time=%0d expected 0/0", bus.emu_dt, bus.emu_time);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== 32'(exp_dt[i]))
        $display("FAIL basic_dt[%0d]: got %0d expected %0d", i, bus.emu_dt, exp_dt[i]);
      else n_pass++;
      n_total++;
      if (bus.emu_time !== 64'(exp_time[i]))
        $display("FAIL basic_time[%0d]: got %0d expected %0d", i, bus.emu_time, exp_time[i]);
      else n_pass++;
      n_total++;
      if (bus.clk_edge !== exp_edge[i])
        $display("FAIL basic_edge[%0d]: got %b expected %b", i, bus.clk_edge, exp_edge[i]);
      else n_pass++;
      n_total++;
      if (bus.clk_val !== exp_val[i])
        $display("FAIL basic_val[%0d]: got %b expected %b", i, bus.clk_val, exp_val[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sync_edges();
    logic [1:0] exp_val [3] = '{2'b11, 2'b00, 2'b11};
    start(4, 4, 4, 4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== 32'd4 || bus.clk_edge !== 2'b11 || bus.clk_val !== exp_val[i]
          || bus.emu_time !== 64'(4 * (i + 1)))
        $display("FAIL sync_step[%0d]: got dt=%0d edge=%b val=%b time=%0d expected 4/11/%b/%0d",
                 i, bus.emu_dt, bus.clk_edge, bus.clk_val, bus.emu_time, exp_val[i], 4 * (i + 1));
      else n_pass++;
    end
  endtask

  task automatic test_dt_max();
    int         exp_dt   [3] = '{2, 2, 1};
    int         exp_time [3] = '{2, 4, 5};
    logic [1:0] exp_edge [3] = '{2'b00, 2'b00, 2'b01};
    start(5, 100, 5, 100, 2, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== 32'(exp_dt[i]) || bus.emu_time !== 64'(exp_time[i])
          || bus.clk_edge !== exp_edge[i])
        $display("FAIL dtmax_step[%0d]: got dt=%0d time=%0d edge=%b expected %0d/%0d/%b",
                 i, bus.emu_dt, bus.emu_time, bus.clk_edge, exp_dt[i], exp_time[i], exp_edge[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stop();
    start(3, 100, 5, 100, 0, 7);
    @(posedge emu_clk); #1;
    n_total++;
    if (bus.emu_dt !== 32'd3 || bus.done !== 1'b0 || bus.clk_edge !== 2'b01)
      $display("FAIL stop_step1: got dt=%0d done=%b edge=%b expected 3/0/01",
               bus.emu_dt, bus.done, bus.clk_edge);
    else n_pass++;
    @(posedge emu_clk); #1;
    n_total++;
    if (bus.emu_dt !== 32'd4 || bus.emu_time !== 64'd7 || bus.done !== 1'b1)
      $display("FAIL stop_step2: got dt=%0d time=%0d done=%b expected 4/7/1",
               bus.emu_dt, bus.emu_time, bus.done);
    else n_pass++;
    for (int i = 0; i < 2; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== '0 || bus.emu_time !== 64'd7 || bus.done !== 1'b1 || bus.clk_edge !== 2'b00)
        $display("FAIL stop_frozen[%0d]: got dt=%0d time=%0d done=%b edge=%b expected 0/7/1/00",
                 i, bus.emu_dt, bus.emu_time, bus.done, bus.clk_edge);
      else n_pass++;
    end
  endtask

  task automatic test_en_pause();
    int exp_time [3] = '{6, 8, 10};
    start(3, 4, 5, 2, 0, 0);
    repeat (2) @(posedge emu_clk);
    #1;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== '0 || bus.emu_time !== 64'd4 || bus.clk_val !== 2'b11 || bus.clk_edge !== 2'b00)
        $display("FAIL pause[%0d]: got dt=%0d time=%0d val=%b edge=%b expected 0/4/11/00",
                 i, bus.emu_dt, bus.emu_time, bus.clk_val, bus.clk_edge);
      else n_pass++;
    end
    bus.en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== 32'd2 || bus.emu_time !== 64'(exp_time[i]))
        $display("FAIL resume[%0d]: got dt=%0d time=%0d expected 2/%0d",
                 i, bus.emu_dt, bus.emu_time, exp_time[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_phase();
    start(0, 10, 0, 10, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge emu_clk); #1;
      n_total++;
      if (bus.emu_dt !== 32'd1 || bus.emu_time !== 64'(i + 1) || bus.clk_edge !== 2'b01
          || bus.clk_val[0] !== ((i % 2) == 0))
        $display("FAIL zero_phase[%0d]: got dt=%0d time=%0d edge=%b val=%b expected 1/%0d/01/bit0=%0d",
                 i, bus.emu_dt, bus.emu_time, bus.clk_edge, bus.clk_val, i + 1, (i % 2) == 0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midrun();
    start(3, 4, 5, 2, 0, 0);
    repeat (2) @(posedge emu_clk);
    #3;
    emu_rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.clk_val, bus.clk_edge, bus.emu_dt, bus.emu_time, bus.done, bus.time_ovf} !== '0)
      $display("FAIL reset_midrun: got val=%b edge=%b dt=%0d time=%0d done=%b ovf=%b expected all zero",
               bus.clk_val, bus.clk_edge, bus.emu_dt, bus.emu_time, bus.done, bus.time_ovf);
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    emu_rst_n = 1'b0;
    test_reset();
    test_basic();
    test_sync_edges();
    test_dt_max();
    test_stop();
    test_en_pause();
    test_zero_phase();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_osc_scheduler.md
Name: multi_osc_scheduler

Overview:
- Emulation-time scheduler for the multi-clock testbench. It owns one timing slot per emulated oscillator and each cycle selects the global timestep dt as the smallest time-to-next-edge across all oscillators.
- It advances the global emulation time by dt and toggles every oscillator whose edge lands exactly on that step.
- It replaces free-running per-oscillator clocks with a single emu_clk domain and signals completion at a programmable stop time.

Parameters:
- NUM_OSC, 2, number of emulated oscillators.
- DT_WIDTH, 32, width of t_lo/t_hi/dt, in DT_SCALE units.
- TIME_WIDTH, 64, width of the emulation time counter.

Ports:
- emu_clk  input  1  emulator clock; single clock domain.
- emu_rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; low freezes time and oscillators.
- t_lo  input  NUM_OSC*DT_WIDTH  packed low-phase durations, slot i at [i*DT_WIDTH +: DT_WIDTH].
- t_hi  input  NUM_OSC*DT_WIDTH  packed high-phase durations.
- dt_max  input  DT_WIDTH  step ceiling; 0 = unlimited.
- stop_time  input  TIME_WIDTH  completion time; 0 = never stop.
- clk_val  output  NUM_OSC  emulated clock levels.
- clk_edge  output  NUM_OSC  one-cycle pulse when clk_val[i] toggled this cycle.
- emu_dt  output  DT_WIDTH  step applied this cycle; 0 if no step.
- emu_time  output  TIME_WIDTH  accumulated emulation time.
- done  output  1  stop_time reached (sticky).
- time_ovf  output  1  sticky; emu_time wrapped.

Behaviour:
- Reset values (asynchronous): state=IDLE, clk_val=0, clk_edge=0, emu_dt=0, emu_time=0, done=0, time_ovf=0, remain[i]=0. Reset mid-run returns everything here immediately.
- All outputs are registered.
- Effective duration: eff(x) = (x==0) ? 1 : x. Zero-length phases are illegal; clamping prevents a dt=0 livelock.

FSM:
- IDLE: on an edge with en=1, remain[i] <= eff(t_lo[i]) and state goes to RUN. No step is taken on this edge.
- RUN, en=0: hold all state; emu_dt <= 0; clk_edge <= 0.
- RUN, en=1: take one step per edge, as below.
- DONE: frozen; emu_dt=0, clk_edge=0, done=1. Exit only via reset.

Step in RUN with en=1:
- dt = min(min_i remain[i], dt_max==0 ? all-ones : dt_max, stop_time!=0 ? stop_time-emu_time : all-ones). The last term is truncated/saturated to DT_WIDTH.
- For each slot i:
  - If remain[i]==dt: clk_val[i] toggles, clk_edge[i] <= 1, remain[i] <= eff(t_hi[i]) if the new level is 1, else eff(t_lo[i]).
  - Otherwise: remain[i] -= dt, clk_edge[i] <= 0.
- Multiple slots may toggle on the same step; all are handled in parallel.
- emu_dt <= dt. emu_time <= emu_time + dt, wrapping modulo 2^TIME_WIDTH; a carry-out sets time_ovf.
- If stop_time!=0 and emu_time+dt==stop_time: state goes to DONE and done <= 1 on the same edge.
- t_lo/t_hi are sampled only at load/reload. Changes take effect at the next edge of that slot; no retroactive adjustment.
- Latency: the first step happens on the second enabled edge after leaving reset (one LOAD edge in IDLE, then steps).

Decomposition:
- Package multi_osc_sched_pkg:
  - DT_WIDTH/TIME_WIDTH defaults.
  - typedefs dt_t, emu_time_t.
  - enum sched_state_t {IDLE, RUN, DONE}.
  - function eff_dt().
- Sub-module osc_slot, one per oscillator:
  - Holds remain and clk_val.
  - Inputs: load, step, dt, t_lo, t_hi.
  - Outputs: remain, clk_val, clk_edge.
- The top level holds the FSM, the combinational min-reduction across slots and the time counter.

Test Plan:
- t_lo=(3,4), t_hi=(5,2), dt_max=0, stop=0, en=1 -> emu_dt sequence 3,1,2,2,2; emu_time 3,4,6,8,10; clk_edge 01,10,10,01,10 (bit1,bit0); clk_val after step5 = 10.
- t_lo=(4,4), t_hi=(4,4) -> every step dt=4; clk_edge=11 each step; clk_val 11,00,11.
- One slot, t_lo=5, t_hi=5, dt_max=2 -> emu_dt 2,2,1; clk_edge only on the third step; emu_time=5.
- Slot 0 with t_lo=3, t_hi=5 (first scenario's values), stop_time=7 -> steps 3,4; done=1 with emu_time=7; further edges leave emu_dt=0 and emu_time=7.
- en dropped for 3 cycles mid-run -> emu_dt=0, emu_time and clk_val frozen; the sequence resumes unchanged when en returns.
- t_lo=0 on one slot -> dt=1 steps, no hang. Separately: emu_rst_n asserted mid-run -> all outputs read 0 before the next emu_clk edge.
